axil_sram_slave: RTL and testbench



---
 rtl/axil_sram_slave_pkg.sv | 26 ++
 rtl/axil_lat_lfsr.sv | 27 ++
 rtl/axil_sram_slave.sv | 224 ++++++++++++++++++++++
 tb/tb_axil_sram_slave.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_sram_slave_pkg.sv
// Shared definitions for the AXI4-Lite SRAM subordinate: response codes,
// FSM encoding, latency counter width and the random-delay LFSR seed/step.
package axil_sram_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [7:0] LFSR_SEED   = 8'hA5;

    // Wide enough for LATENCY (0..15) plus the optional 0..7 random extension
    localparam int CNT_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_RD_RESP = 3'd2,
        ST_WR_WAIT = 3'd3,
        ST_WR_RESP = 3'd4
    } state_e;

    // Fibonacci step for x^8+x^6+x^5+x^4+1, shifting towards the MSB
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/axil_lat_lfsr.sv
// 8-bit LFSR that randomises response latency; only instantiated by
// axil_sram_slave when AXIL_SRAM_RAND_DELAY_EN is defined.
module axil_lat_lfsr
    import axil_sram_slave_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    output logic [7:0] state
);

    logic [7:0] lfsr_r;

    // Advance once per accepted request, reseed on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_r <= LFSR_SEED;
        end else if (step) begin
            lfsr_r <= lfsr_next(lfsr_r);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    assign state = lfsr_r;

endmodule

// File: rtl/axil_sram_slave.sv
// AXI4-Lite single-beat SRAM subordinate with configurable response latency.
// Define AXIL_SRAM_RAND_DELAY_EN to add an LFSR-driven 0..7 cycle extension.
module axil_sram_slave
    import axil_sram_slave_pkg::*;
#(
    parameter int          DEPTH     = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          LATENCY   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e           state_r;
    state_e           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [CNT_W-1:0] lat_load_s;

    logic [31:0]      addr_r;
    logic [31:0]      wdata_r;
    logic [3:0]       wstrb_r;

    logic [31:0]      dec_addr_s;
    logic [31:0]      word_s;
    logic             in_range_s;
    logic [IDX_W-1:0] idx_s;

    logic             idle_s;
    logic             ar_hs_s;
    logic             wr_hs_s;
    logic             rd_enter_s;
    logic             wr_enter_s;
    logic             wr_commit_r;

    logic             rvalid_r;
    logic             bvalid_r;
    logic [31:0]      rdata_r;
    logic [1:0]       rresp_r;
    logic [1:0]       bresp_r;

    logic [31:0]      mem_r [DEPTH];

`ifdef AXIL_SRAM_RAND_DELAY_EN
    logic [7:0] lfsr_s;

    axil_lat_lfsr u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .step  (ar_hs_s | wr_hs_s),
        .state (lfsr_s)
    );

    assign lat_load_s = CNT_W'(LATENCY) + CNT_W'(lfsr_s[2:0]);
`else
    assign lat_load_s = CNT_W'(LATENCY);
`endif

    // Readies are suppressed during the reset cycle even if the FSM sits in IDLE
    assign idle_s  = (state_r == ST_IDLE) && !rst;
    assign arready = idle_s;
    assign awready = idle_s && !arvalid;
    assign wready  = idle_s && !arvalid;

    assign ar_hs_s = idle_s && arvalid;
    assign wr_hs_s = idle_s && !arvalid && awvalid && wvalid;

    // Decode the incoming address in IDLE so zero-latency responses see it directly
    always_comb begin
        if (state_r == ST_IDLE) begin
            if (arvalid) begin
                dec_addr_s = araddr;
            end else begin
                dec_addr_s = awaddr;
            end
        end else begin
            dec_addr_s = addr_r;
        end
    end

    assign word_s     = (dec_addr_s - BASE_ADDR) >> 5'd2;
    assign in_range_s = (dec_addr_s >= BASE_ADDR) && (word_s < 32'(DEPTH));
    assign idx_s      = word_s[IDX_W-1:0];

    // Next-state and latency counter
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (ar_hs_s) begin
                    cnt_s   = lat_load_s;
                    state_s = (lat_load_s == '0) ? ST_RD_RESP : ST_RD_WAIT;
                end else if (wr_hs_s) begin
                    cnt_s   = lat_load_s;
                    state_s = (lat_load_s == '0) ? ST_WR_RESP : ST_WR_WAIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                if (cnt_r <= CNT_W'(1)) begin
                    cnt_s   = '0;
                    state_s = ST_RD_RESP;
                end else begin
                    cnt_s   = cnt_r - CNT_W'(1);
                    state_s = ST_RD_WAIT;
                end
            end
            ST_RD_RESP: begin
                if (rready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RD_RESP;
                end
            end
            ST_WR_WAIT: begin
                if (cnt_r <= CNT_W'(1)) begin
                    cnt_s   = '0;
                    state_s = ST_WR_RESP;
                end else begin
                    cnt_s   = cnt_r - CNT_W'(1);
                    state_s = ST_WR_WAIT;
                end
            end
            ST_WR_RESP: begin
                if (bready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WR_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // FSM state, counter and request capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            addr_r  <= '0;
            wdata_r <= '0;
            wstrb_r <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (ar_hs_s || wr_hs_s) begin
                addr_r <= dec_addr_s;
            end
            if (wr_hs_s) begin
                wdata_r <= wdata;
                wstrb_r <= wstrb;
            end
        end
    end

    assign rd_enter_s = (state_s == ST_RD_RESP) && (state_r != ST_RD_RESP);
    assign wr_enter_s = (state_s == ST_WR_RESP) && (state_r != ST_WR_RESP);

    // Registered R/B channel outputs, loaded on entry to the response states
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_r    <= 1'b0;
            bvalid_r    <= 1'b0;
            rdata_r     <= 32'd0;
            rresp_r     <= RESP_OKAY;
            bresp_r     <= RESP_OKAY;
            wr_commit_r <= 1'b0;
        end else begin
            rvalid_r    <= (state_s == ST_RD_RESP);
            bvalid_r    <= (state_s == ST_WR_RESP);
            wr_commit_r <= wr_enter_s && in_range_s;
            if (rd_enter_s) begin
                rdata_r <= in_range_s ? mem_r[idx_s] : 32'd0;
                rresp_r <= in_range_s ? RESP_OKAY : RESP_DECERR;
            end
            if (wr_enter_s) begin
                bresp_r <= in_range_s ? RESP_OKAY : RESP_DECERR;
            end
        end
    end

    // Byte-masked array write in the first WR_RESP cycle; a reset arriving once
    // WR_RESP is reached must not cancel it, so rst is intentionally not checked
    always_ff @(posedge clk) begin
        if (wr_commit_r) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_r[b]) begin
                    mem_r[idx_s][8*b +: 8] <= wdata_r[8*b +: 8];
                end
            end
        end
    end

    assign rvalid = rvalid_r;
    assign rdata  = rdata_r;
    assign rresp  = rresp_r;
    assign bvalid = bvalid_r;
    assign bresp  = bresp_r;

endmodule

// File: tb/tb_axil_sram_slave.sv
// Self-checking bench for axil_sram_slave: directed cases plus randomized
// traffic against an associative-array memory model.
module tb_axil_sram_slave;

    localparam int          DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          LAT1  = 1;
    localparam int          LAT5  = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr, awaddr, wdata;
    logic        arvalid, rready, awvalid, wvalid, bready;
    logic [3:0]  wstrb;

    logic        arready, rvalid, awready, wready, bvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;

    logic        arready_5, rvalid_5, awready_5, wready_5, bvalid_5;
    logic [31:0] rdata_5;
    logic [1:0]  rresp_5, bresp_5;

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl [int];
    logic [31:0] pool [10];
    logic [31:0] got;

    always #5 clk = ~clk;

    axil_sram_slave #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT1)) u_dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    axil_sram_slave #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT5)) u_dut5 (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready_5),
        .rdata(rdata_5), .rresp(rresp_5), .rvalid(rvalid_5), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready_5),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready_5),
        .bresp(bresp_5), .bvalid(bvalid_5), .bready(bready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return (a >= BASE) && (((a - BASE) >> 2) < 32'(DEPTH));
    endfunction

    function automatic int key_of(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input bit pre, input int dly);
        int n;
        int k;
        logic [31:0] m;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = pre;
        #1;
        n = 0;
        while (!(awready && wready) && n < 50) begin
            step(); #1; n++;
        end
        check("aw_w_accept", 32'(n < 50), 32'd1);
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        n = 1;
        while (!bvalid && n < 40) begin
            step(); n++;
        end
        check("b_latency", 32'(n), 32'(LAT1 + 1));
        check("bresp", 32'(bresp), in_rng(a) ? 32'd0 : 32'd3);
        if (!pre) begin
            for (int i = 0; i < dly; i++) begin
                step();
                check("bvalid_held", 32'(bvalid), 32'd1);
            end
            bready = 1'b1;
        end
        step();
        bready = 1'b0;
        check("bvalid_after_b", 32'(bvalid), 32'd0);
        if (in_rng(a)) begin
            k = key_of(a);
            if (mdl.exists(k) || s == 4'hF) begin
                m = mdl.exists(k) ? mdl[k] : 32'd0;
                for (int b = 0; b < 4; b++) begin
                    if (s[b]) m[8*b +: 8] = d[8*b +: 8];
                end
                mdl[k] = m;
            end
        end
    endtask

    task automatic axi_read(input logic [31:0] a, input bit pre, input int dly,
                            output logic [31:0] obs);
        int n;
        bit known;
        logic [31:0] exp_d;
        araddr = a; arvalid = 1'b1; rready = pre;
        #1;
        n = 0;
        while (!arready && n < 50) begin
            step(); #1; n++;
        end
        check("ar_accept", 32'(n < 50), 32'd1);
        step();
        arvalid = 1'b0;
        n = 1;
        while (!rvalid && n < 40) begin
            check("arready_busy", 32'(arready), 32'd0);
            step(); n++;
        end
        known = in_rng(a) ? mdl.exists(key_of(a)) : 1'b1;
        exp_d = (in_rng(a) && known) ? mdl[key_of(a)] : 32'd0;
        obs = rdata;
        check("r_latency", 32'(n), 32'(LAT1 + 1));
        check("rresp", 32'(rresp), in_rng(a) ? 32'd0 : 32'd3);
        if (known) check("rdata", rdata, exp_d);
        if (!pre) begin
            for (int i = 0; i < dly; i++) begin
                step();
                check("rvalid_held", 32'(rvalid), 32'd1);
                if (known) check("rdata_held", rdata, exp_d);
                check("arready_held", 32'(arready), 32'd0);
            end
            rready = 1'b1;
        end
        step();
        rready = 1'b0;
        check("rvalid_after_r", 32'(rvalid), 32'd0);
        check("arready_after_r", 32'(arready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        rready = 1'b0; bready = 1'b0;
        araddr = 32'd0; awaddr = 32'd0; wdata = 32'd0; wstrb = 4'd0;
        step(); step();
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready",  32'(wready),  32'd0);
        check("rst_rvalid",  32'(rvalid),  32'd0);
        check("rst_bvalid",  32'(bvalid),  32'd0);
        check("rst_rdata",   rdata,        32'd0);
        check("rst_rresp",   32'(rresp),   32'd0);
        check("rst_bresp",   32'(bresp),   32'd0);
        rst = 1'b0;
        #1;
        check("idle_arready", 32'(arready), 32'd1);
        check("idle_awready", 32'(awready), 32'd1);

        // Full write then read-back, then a partial-strobe merge
        axi_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, 0);
        axi_read(BASE + 32'h10, 1'b0, 0, got);
        check("full_word", got, 32'hDEAD_BEEF);
        axi_write(BASE + 32'h10, 32'h1122_3344, 4'b0101, 1'b1, 0);
        axi_read(BASE + 32'h10, 1'b1, 0, got);
        check("partial_merge", got, 32'hDE22_BE44);
        axi_write(BASE + 32'h10, 32'hFFFF_FFFF, 4'h0, 1'b0, 1);
        axi_read(BASE + 32'h10, 1'b0, 0, got);
        check("zero_strobe", got, 32'hDE22_BE44);

        // Decode boundaries: out-of-range writes must not alias onto the ends
        axi_write(BASE, 32'h0BAD_F00D, 4'hF, 1'b0, 0);
        axi_write(BASE + 32'(4 * (DEPTH - 1)), 32'hCAFE_F00D, 4'hF, 1'b0, 0);
        axi_read(32'h7FFF_FFFC, 1'b0, 0, got);
        check("oor_low_rdata", got, 32'd0);
        axi_read(BASE + 32'(4 * DEPTH), 1'b0, 0, got);
        check("oor_high_rdata", got, 32'd0);
        axi_write(BASE + 32'(4 * DEPTH), 32'h1234_5678, 4'hF, 1'b0, 0);
        axi_write(32'h7FFF_FFFC, 32'h8765_4321, 4'hF, 1'b1, 0);
        axi_read(BASE, 1'b0, 0, got);
        check("first_word_kept", got, 32'h0BAD_F00D);
        axi_read(BASE + 32'(4 * (DEPTH - 1)), 1'b0, 0, got);
        check("last_word_kept", got, 32'hCAFE_F00D);

        // Read backpressure
        axi_read(BASE + 32'h10, 1'b0, 5, got);

        // AW alone or W alone is never accepted
        awaddr = BASE + 32'h20; wdata = 32'h0; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("aw_only_no_b", 32'(bvalid), 32'd0);
        end
        awvalid = 1'b0; wvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("w_only_no_b", 32'(bvalid), 32'd0);
        end
        wvalid = 1'b0;
        axi_write(BASE + 32'h20, 32'h55AA_33CC, 4'hF, 1'b0, 1);

        // Read wins over a simultaneous write; the write goes once back in IDLE
        araddr = BASE + 32'h10; arvalid = 1'b1;
        awaddr = BASE + 32'h24; wdata = 32'h1357_9BDF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        #1;
        check("prio_arready", 32'(arready), 32'd1);
        check("prio_awready", 32'(awready), 32'd0);
        check("prio_wready",  32'(wready),  32'd0);
        axi_read(BASE + 32'h10, 1'b0, 0, got);
        check("prio_awready_idle", 32'(awready), 32'd1);
        axi_write(BASE + 32'h24, 32'h1357_9BDF, 4'hF, 1'b0, 0);
        axi_read(BASE + 32'h24, 1'b1, 0, got);
        check("prio_write_data", got, 32'h1357_9BDF);

        // Randomized traffic over in-range and out-of-range addresses
        pool[0] = BASE;                   pool[1] = BASE + 32'h4;
        pool[2] = BASE + 32'h8;           pool[3] = BASE + 32'hC;
        pool[4] = BASE + 32'h40;          pool[5] = BASE + 32'(4 * (DEPTH - 1));
        pool[6] = BASE - 32'h4;           pool[7] = BASE + 32'(4 * DEPTH);
        pool[8] = 32'h0000_0100;          pool[9] = 32'hFFFF_FFFC;
        for (int i = 0; i < 6; i++) axi_write(pool[i], $urandom, 4'hF, 1'b0, 0);
        for (int it = 0; it < 80; it++) begin
            logic [31:0] a;
            bit          pre;
            int          dly;
            a   = pool[$urandom_range(0, 9)] | 32'($urandom_range(0, 3));
            pre = 1'($urandom_range(0, 1));
            dly = int'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                axi_write(a, $urandom, 4'($urandom_range(0, 15)), pre, dly);
            else
                axi_read(a, pre, dly, got);
        end

        // Reset while the LATENCY=5 instance is waiting drops the response
        rst = 1'b1; step(); rst = 1'b0;
        araddr = BASE + 32'h10; arvalid = 1'b1; rready = 1'b0;
        #1;
        check("lat5_arready", 32'(arready_5), 32'd1);
        step();
        arvalid = 1'b0;
        step(); step();
        check("lat5_waiting", 32'(rvalid_5), 32'd0);
        rst = 1'b1;
        #1;
        check("lat5_arready_in_rst", 32'(arready_5), 32'd0);
        step();
        rst = 1'b0;
        #1;
        check("lat5_rvalid_after_rst",  32'(rvalid_5),  32'd0);
        check("lat5_arready_after_rst", 32'(arready_5), 32'd1);
        check("lat1_rvalid_after_rst",  32'(rvalid),    32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("lat5_no_stale", 32'(rvalid_5), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
